// File: rtl/silife_grid_dumper_if.sv
// ============================================================================
//  Module   : silife_grid_dumper_if
//  Purpose  : Serial dump port bundle (chip select, serial clock, MOSI, MISO,
//             MISO pad output enable) between an SPI-like master and the
//             grid dumper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface silife_grid_dumper_if;
  logic i_dump_cs;
  logic i_dump_clk;
  logic i_dump_data;
  logic o_dump_data;
  logic o_dump_oe;

  modport master (
    output i_dump_cs,
    output i_dump_clk,
    output i_dump_data,
    input  o_dump_data,
    input  o_dump_oe
  );

  modport slave (
    input  i_dump_cs,
    input  i_dump_clk,
    input  i_dump_data,
    output o_dump_data,
    output o_dump_oe
  );
endinterface

`default_nettype wire

// File: rtl/silife_grid_dumper.sv
// ============================================================================
//  Module   : silife_grid_dumper
//  Purpose  : Serial read-back of the cell grid. The master sends a 15-bit
//             segment address and a 16-bit start row (MSB first). When the
//             segment matches this chip, whole rows are fetched and shifted
//             out MSB (cell WIDTH-1) first, one bit per serial clock, with
//             rows auto-incrementing and wrapping at HEIGHT.
//  Options  : SILIFE_DUMP_PARITY_EN - append an even-parity bit after each
//             row (WIDTH+1 serial clocks per row).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module silife_grid_dumper #(
  parameter  int WIDTH    = 32,
  parameter  int HEIGHT   = 32,
  localparam int ROW_BITS = $clog2(HEIGHT)
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  silife_grid_dumper_if.slave       dump,
  input  wire logic [14:0]          i_local_address,
  output logic      [ROW_BITS-1:0]  o_row_select,
  input  wire logic [WIDTH-1:0]     i_row_cells,
  output logic                      o_active
);

  // One counter serves the address phases (up to 15) and the cell phase.
  localparam int CNT_BITS = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEG   = 3'd1,
    S_ROW   = 3'd2,
    S_FETCH = 3'd3,
    S_CELL  = 3'd4
  } state_t;

  logic [1:0]          cs_sync_q;
  logic [1:0]          sclk_sync_q;
  logic [1:0]          mosi_sync_q;
  logic                sclk_prev_q;

  state_t              state_q;
  logic [14:0]         seg_q;
  logic [15:0]         row_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                fetch_ph_q;
  logic [WIDTH-1:0]    shift_q;
  logic [ROW_BITS-1:0] row_sel_q;
  logic                dump_data_q;
  logic                dump_oe_q;
  logic                active_q;
`ifdef SILIFE_DUMP_PARITY_EN
  logic                parity_q;
  logic                par_ph_q;
`endif

  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic matched;

  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_prev_q;
  // The broadcast segment never drives MISO so several chips cannot fight.
  assign matched   = (seg_q == i_local_address) && (seg_q != 15'h7fff);

  assign dump.o_dump_data = dump_data_q;
  assign dump.o_dump_oe   = dump_oe_q;
  assign o_row_select     = row_sel_q;
  assign o_active         = active_q;

  // Two-flop synchronizers for the asynchronous serial inputs plus edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0],   dump.i_dump_cs};
      sclk_sync_q <= {sclk_sync_q[0], dump.i_dump_clk};
      mosi_sync_q <= {mosi_sync_q[0], dump.i_dump_data};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  // Command decode, row fetch and cell shifting with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      seg_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      fetch_ph_q  <= 1'b0;
      shift_q     <= '0;
      row_sel_q   <= '0;
      dump_data_q <= 1'b0;
      dump_oe_q   <= 1'b0;
      active_q    <= 1'b0;
`ifdef SILIFE_DUMP_PARITY_EN
      parity_q    <= 1'b0;
      par_ph_q    <= 1'b0;
`endif
    end else if (cs_s) begin
      // Deselect aborts any transfer; the grid is never written, so nothing to undo.
      state_q    <= S_IDLE;
      seg_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      fetch_ph_q <= 1'b0;
      dump_oe_q  <= 1'b0;
      active_q   <= 1'b0;
`ifdef SILIFE_DUMP_PARITY_EN
      par_ph_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sclk_rise) begin
            seg_q   <= {14'd0, mosi_s};
            cnt_q   <= CNT_BITS'(13);
            state_q <= S_SEG;
          end
        end
        // Address bits arrive MSB first, so shifting left lands them in place.
        S_SEG: begin
          if (sclk_rise) begin
            seg_q <= {seg_q[13:0], mosi_s};
            if (cnt_q == '0) begin
              cnt_q   <= CNT_BITS'(15);
              state_q <= S_ROW;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        S_ROW: begin
          if (sclk_rise) begin
            row_q <= {row_q[14:0], mosi_s};
            if (cnt_q == '0) begin
              fetch_ph_q <= 1'b0;
              state_q    <= S_FETCH;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        // Cycle 1 presents the row to the grid, cycle 2 captures its cells.
        S_FETCH: begin
          if (!fetch_ph_q) begin
            row_sel_q  <= row_q[ROW_BITS-1:0];
            fetch_ph_q <= 1'b1;
          end else begin
            shift_q    <= i_row_cells;
            cnt_q      <= CNT_BITS'(WIDTH - 1);
            active_q   <= matched;
            fetch_ph_q <= 1'b0;
            state_q    <= S_CELL;
`ifdef SILIFE_DUMP_PARITY_EN
            parity_q   <= ^i_row_cells;
`endif
          end
        end
        S_CELL: begin
          if (sclk_fall) begin
`ifdef SILIFE_DUMP_PARITY_EN
            dump_data_q <= par_ph_q ? parity_q : shift_q[WIDTH-1];
`else
            dump_data_q <= shift_q[WIDTH-1];
`endif
            dump_oe_q   <= matched;
          end else if (sclk_rise) begin
`ifdef SILIFE_DUMP_PARITY_EN
            if (par_ph_q) begin
              par_ph_q <= 1'b0;
              row_q    <= row_q + 16'd1;
              state_q  <= S_FETCH;
            end else begin
              shift_q <= {shift_q[WIDTH-2:0], 1'b0};
              if (cnt_q == '0) begin
                par_ph_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
`else
            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
              row_q   <= row_q + 16'd1;
              state_q <= S_FETCH;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_silife_grid_dumper.sv
// ============================================================================
//  Module   : tb_silife_grid_dumper
//  Purpose  : Self-checking bench for silife_grid_dumper. A serial master
//             issues dump commands against a randomly filled grid; expected
//             MISO bits come from a row/bit walk over the grid array.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_silife_grid_dumper;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int RB = $clog2(H);
`ifdef SILIFE_DUMP_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [14:0]   local_addr;
  logic [RB-1:0] row_sel;
  logic [W-1:0]  row_cells;
  logic          active;
  logic [W-1:0]  grid [H];

  int tests = 0;
  int fails = 0;

  silife_grid_dumper_if dif ();

  silife_grid_dumper #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .dump            (dif),
    .i_local_address (local_addr),
    .o_row_select    (row_sel),
    .i_row_cells     (row_cells),
    .o_active        (active)
  );

  assign row_cells = grid[row_sel];

  always #5 clk = ~clk;

  // One serial clock: fall, low phase, sample at end of low phase, rise, high phase.
  task automatic sclk_cycle(input logic mosi, output logic miso, output logic oe,
                            output logic act, output logic [RB-1:0] rs);
    dif.i_dump_clk  = 1'b0;
    dif.i_dump_data = mosi;
    repeat (8) @(negedge clk);
    miso = dif.o_dump_data;
    oe   = dif.o_dump_oe;
    act  = active;
    rs   = row_sel;
    dif.i_dump_clk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [14:0] seg, input logic [15:0] row);
    logic m, o, a;
    logic [RB-1:0] r;
    dif.i_dump_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 14; i >= 0; i--) sclk_cycle(seg[i], m, o, a, r);
    for (int i = 15; i >= 0; i--) sclk_cycle(row[i], m, o, a, r);
  endtask

  task automatic end_cmd();
    dif.i_dump_clk = 1'b0;
    repeat (2) @(negedge clk);
    dif.i_dump_cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Reference: walk rows from start (mod H), WIDTH bits MSB first, optional parity.
  task automatic run_data(input string name, input logic [15:0] start, input int nclk,
                          input logic exp_m);
    int r = int'(start) % H;
    int b = 0;
    logic exp_bit, miso, oe, act;
    logic [RB-1:0] rs;
    for (int n = 0; n < nclk; n++) begin
      exp_bit = (b < W) ? grid[r][W-1-b] : ^grid[r];
      sclk_cycle(1'b0, miso, oe, act, rs);
      tests++;
      if (oe !== exp_m) begin
        fails++;
        $display("FAIL %s oe clk%0d: got %b want %b", name, n, oe, exp_m);
      end
      tests++;
      if (act !== exp_m) begin
        fails++;
        $display("FAIL %s active clk%0d: got %b want %b", name, n, act, exp_m);
      end
      tests++;
      if (rs !== RB'(r)) begin
        fails++;
        $display("FAIL %s row_select clk%0d: got %0d want %0d", name, n, rs, r);
      end
      if (exp_m) begin
        tests++;
        if (miso !== exp_bit) begin
          fails++;
          $display("FAIL %s miso clk%0d: got %b want %b", name, n, miso, exp_bit);
        end
      end
      b++;
      if (b == W + PAR) begin
        b = 0;
        r = (r + 1) % H;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dif.i_dump_cs = 1'b0;
    for (int i = 0; i < 12; i++) begin
      dif.i_dump_clk  = ~dif.i_dump_clk;
      dif.i_dump_data = 1'($urandom);
      repeat (4) @(negedge clk);
      tests++;
      if ({dif.o_dump_oe, dif.o_dump_data, row_sel, active} !== '0) begin
        fails++;
        $display("FAIL reset outputs: oe=%b data=%b rs=%0d act=%b want all 0",
                 dif.o_dump_oe, dif.o_dump_data, row_sel, active);
      end
    end
    dif.i_dump_cs  = 1'b1;
    dif.i_dump_clk = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single_row();
    local_addr = 15'h0005;
    grid[3] = 32'hA5F0_0001;
    send_cmd(15'd5, 16'd3);
    run_data("single", 16'd3, W, 1'b1);
    end_cmd();
  endtask

  task automatic test_mismatch();
    local_addr = 15'h0005;
    send_cmd(15'd6, 16'($urandom_range(0, 65535)));
    run_data("mismatch", 16'd0, 0, 1'b0);
    run_data("mismatch_seg6", 16'd0, 0, 1'b0);
    end_cmd();
    send_cmd(15'h7fff, 16'd2);
    run_data("broadcast", 16'd2, 6, 1'b0);
    end_cmd();
    local_addr = 15'h7fff;
    send_cmd(15'h7fff, 16'd4);
    run_data("broadcast_local", 16'd4, 6, 1'b0);
    end_cmd();
    local_addr = 15'h0005;
    send_cmd(15'd6, 16'd8);
    run_data("mismatch_seg6", 16'd8, 6, 1'b0);
    end_cmd();
  endtask

  task automatic test_wrap();
    local_addr = 15'h1234;
    send_cmd(15'h1234, 16'd31);
    run_data("wrap", 16'd31, 2 * (W + PAR), 1'b1);
    end_cmd();
  endtask

  task automatic test_random();
    logic [14:0] seg;
    logic [15:0] row;
    logic m;
    for (int k = 0; k < 4; k++) begin
      local_addr = 15'($urandom_range(0, 32766));
      m   = 1'($urandom);
      seg = m ? local_addr : (local_addr ^ 15'($urandom_range(1, 32767)));
      m   = m && (seg != 15'h7fff);
      row = 16'($urandom);
      send_cmd(seg, row);
      run_data("random", row, $urandom_range(5, 40), m);
      end_cmd();
    end
  endtask

  task automatic test_abort();
    local_addr = 15'h0042;
    send_cmd(15'h0042, 16'($urandom_range(0, 31)));
    run_data("abort_pre", 16'(row_sel), 10, 1'b1);
    dif.i_dump_cs = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (dif.o_dump_oe !== 1'b0) begin
      fails++;
      $display("FAIL abort oe: got %b want 0 three cycles after cs high", dif.o_dump_oe);
    end
    tests++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL abort active: got %b want 0", active);
    end
    dif.i_dump_clk = 1'b0;
    repeat (10) @(negedge clk);
    send_cmd(15'h0042, 16'd7);
    run_data("abort_restart", 16'd7, W, 1'b1);
    end_cmd();
  endtask

  task automatic test_parity();
    local_addr = 15'h0011;
    grid[9] = 32'h0000_0007;
    send_cmd(15'h0011, 16'd9);
    run_data("parity", 16'd9, 2 * (W + PAR), 1'b1);
    end_cmd();
  endtask

  task automatic test_reset_mid();
    logic m, o, a;
    logic [RB-1:0] r;
    local_addr = 15'h0003;
    send_cmd(15'h0003, 16'd5);
    for (int i = 0; i < 5; i++) sclk_cycle(1'b0, m, o, a, r);
    reset_n = 1'b0;
    #1;
    tests++;
    if ({dif.o_dump_oe, dif.o_dump_data, row_sel, active} !== '0) begin
      fails++;
      $display("FAIL reset_mid outputs: oe=%b data=%b rs=%0d act=%b want all 0",
               dif.o_dump_oe, dif.o_dump_data, row_sel, active);
    end
    dif.i_dump_cs  = 1'b1;
    dif.i_dump_clk = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < H; i++) grid[i] = W'($urandom);
    local_addr      = 15'h0005;
    dif.i_dump_cs   = 1'b1;
    dif.i_dump_clk  = 1'b0;
    dif.i_dump_data = 1'b0;
    reset_n         = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_row();
    test_mismatch();
    test_wrap();
    test_random();
    test_abort();
    test_parity();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
